// File: rtl/ppm_encoder_if.sv
// Byte-stream handshake between the frame buffer (master) and the PPM encoder (slave).
interface ppm_encoder_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/ppm_encoder.sv
// 1-out-of-4 PPM transmitter on the 16x clock: SOF symbol, four dibit symbols per byte
// (LSB dibit first), EOF symbol. Line idles high, pulses are active-low.
module ppm_encoder #(
  parameter int SLOT_CYC  = 16,
  parameter int PULSE_CYC = 4,
  parameter int EOF_LOW   = 7,
  parameter int SOF_LOW   = 12
) (
  input  logic          clk16,
  input  logic          rst_n,
  ppm_encoder_if.slave  tx,
  output logic          Dout,
  output logic          busy,
  output logic          frame_done,
  output logic          underrun
);

  localparam int SYM = 4 * SLOT_CYC;
  localparam int CW  = $clog2(SYM);
  localparam logic [CW-1:0] CYC_LAST = CW'(SYM - 1);

  typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc_cnt, cyc_n;
  logic [1:0]    sym_cnt, sym_n;
  logic [7:0]    byte_q, byte_n;
  logic          last_q, last_n;
  logic          dout_q;
  logic          sym_end, boundary, accept;
  logic [7:0]    byte_sh;

  // Line level for a given position; data symbols are low only inside their pulse slot.
  function automatic logic line_level(state_t st, logic [CW-1:0] cyc, logic [1:0] d);
    int c;
    int lo;
    c  = int'(cyc);
    lo = int'(d) * SLOT_CYC;
    case (st)
      SOF:     line_level = !(c < SOF_LOW);
      DATA:    line_level = !((c >= lo) && (c < lo + PULSE_CYC));
      EOF:     line_level = !(c < EOF_LOW);
      default: line_level = 1'b1;
    endcase
  endfunction

  assign sym_end     = (cyc_cnt == CYC_LAST);
  assign boundary    = (state == DATA) && sym_end && (sym_cnt == 2'd3);
  assign tx.tx_ready = rst_n & ((state == IDLE) | (boundary & ~last_q));
  assign accept      = tx.tx_valid & tx.tx_ready;

  assign Dout       = dout_q;
  assign busy       = (state != IDLE);
  assign frame_done = rst_n & (state == EOF) & sym_end;
  assign underrun   = rst_n & boundary & ~last_q & ~tx.tx_valid;

  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt + 1'b1;
    sym_n   = sym_cnt;
    byte_n  = byte_q;
    last_n  = last_q;
    case (state)
      IDLE: begin
        cyc_n = '0;
        if (accept) begin
          state_n = SOF;
          byte_n  = tx.tx_data;
          last_n  = tx.tx_last;
        end
      end
      SOF: begin
        if (sym_end) begin
          state_n = DATA;
          cyc_n   = '0;
          sym_n   = 2'd0;
        end
      end
      DATA: begin
        if (sym_end) begin
          cyc_n = '0;
          sym_n = sym_cnt + 2'd1;
          // A byte accepted at the boundary continues with no idle gap.
          if (sym_cnt == 2'd3) begin
            if (accept) begin
              byte_n = tx.tx_data;
              last_n = tx.tx_last;
            end else begin
              state_n = EOF;
            end
          end
        end
      end
      EOF: begin
        if (sym_end) begin
          state_n = IDLE;
          cyc_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_sh = byte_n >> {sym_n, 1'b0};

  // Control state and the registered line output.
  always_ff @(posedge clk16) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      sym_cnt <= '0;
      dout_q  <= 1'b1;
    end else begin
      state   <= state_n;
      cyc_cnt <= cyc_n;
      sym_cnt <= sym_n;
      dout_q  <= line_level(state_n, cyc_n, byte_sh[1:0]);
    end
  end

  always_ff @(posedge clk16) begin
    byte_q <= byte_n;
    last_q <= last_n;
  end

endmodule
